ticket_ctrl: RTL and testbench
==============================

TICKET_CTRL -- requirements
Module: ticket_ctrl

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, 100, number of clk cycles the DONE state holds the display before returning to IDLE (minimum 1).
REQ-002 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: sel_type  in  3  ticket type selection; 0=5, 1=10, 2=20, 3 and above=30 per ticket.
REQ-005 SHALL have port: sel_count  in  3  number of tickets requested, 0..7.
REQ-006 SHALL have port: coin_valid  in  1  single-cycle pulse; one coin inserted.
REQ-007 SHALL have port: coin_value  in  2  coin code qualified by coin_valid: 0=1, 1=5, 2=10, 3=20.
REQ-008 SHALL have port: confirm  in  1  single-cycle purchase request.
REQ-009 SHALL have port: cancel  in  1  single-cycle abort request.
REQ-010 SHALL have port: money  out  8  total inserted credit, binary, to the display scanner.
REQ-011 SHALL have port: ticketType  out  3  latched ticket type, to the display scanner.
REQ-012 SHALL have port: ticketCount  out  3  latched ticket count, to the display scanner.
REQ-013 SHALL have port: moneyReturn  out  8  total change owed for the current transaction, held for display.
REQ-014 SHALL have port: ticket_pulse  out  1  one-cycle pulse per ticket dispensed.
REQ-015 SHALL have port: change_pulse  out  1  one-cycle pulse per change coin ejected.
REQ-016 SHALL have port: change_coin  out  2  coin code qualified by change_pulse: 0=1, 1=5, 2=10.
REQ-017 SHALL have port: coin_reject  out  1  one-cycle pulse, one cycle after a coin that was not accepted.
REQ-018 SHALL have port: busy  out  1  high in DISPENSE, CHANGE and DONE.

Function
REQ-019 SHALL implement states IDLE, PAY, DISPENSE, CHANGE, DONE.
REQ-020 SHALL compute price = unit price x ticketCount in 8 bits; the maximum of 210 never overflows.
REQ-021 In IDLE, ticketType and ticketCount SHALL track sel_type and sel_count every cycle; money and moneyReturn SHALL be 0.
REQ-022 An accepted coin in IDLE SHALL add its value to money, freeze ticketType and ticketCount, and move to PAY on the next edge.
REQ-023 In PAY, each coin SHALL be added to money; a coin making money exceed 255 SHALL be discarded and SHALL raise coin_reject.
REQ-024 A coin arriving in DISPENSE, CHANGE or DONE SHALL be discarded and SHALL raise coin_reject.
REQ-025 In PAY, confirm SHALL be accepted only if coin_valid=0, ticketCount is not 0, and money >= price; otherwise it SHALL be ignored with no state change.
REQ-026 An accepted confirm SHALL move to DISPENSE; the first ticket_pulse SHALL occur the cycle after entry.
REQ-027 DISPENSE SHALL emit exactly ticketCount pulses on consecutive cycles.
REQ-028 After the final ticket pulse, DISPENSE SHALL load moneyReturn = money - price and move to CHANGE.
REQ-029 cancel in PAY SHALL set moneyReturn = money, emit no tickets, and move to CHANGE; cancel SHALL win over a same-cycle confirm.
REQ-030 cancel SHALL be ignored in IDLE, DISPENSE, CHANGE and DONE.
REQ-031 In CHANGE, each cycle SHALL eject the largest coin (10, 5 or 1) not exceeding the internal remainder and decrement the remainder by that coin.
REQ-032 In CHANGE, moneyReturn SHALL stay constant.
REQ-033 When the remainder is 0, CHANGE SHALL move to DONE; zero change SHALL move to DONE in one cycle with no change pulses.
REQ-034 DONE SHALL hold all display outputs for HOLD_CYCLES cycles, then return to IDLE with money and moneyReturn cleared.
REQ-035 ticket_pulse and change_pulse SHALL never be asserted in the same cycle.

Reset
REQ-036 rst low SHALL immediately force state IDLE and drive money, moneyReturn, ticketType, ticketCount, all pulse outputs, busy, change_coin and all internal counters to 0.
REQ-037 Reset asserted during DISPENSE or CHANGE SHALL abort the transaction with no further pulses after release; credit is lost by design.

Structure
REQ-038 Package ticket_pkg SHALL hold the state enum, the coin-code and change-coin constants, the unit prices 5, 10, 20 and 30, and a price(type,count) function.
REQ-039 Change decomposition (remainder register, largest-coin select, pulse generation) SHALL be a sub-module named change_gen with start, amount, done and pulse/coin outputs.

Verification
REQ-040 Bench SHALL cover normal purchase: type 1, count 2, coins 20+5 then confirm -> 2 ticket pulses; moneyReturn=5; one change pulse with code 1; DONE, then IDLE after HOLD_CYCLES.
REQ-041 Bench SHALL cover insufficient credit: type 3, count 3, coins 20+20+20+20 (money=80, price=90) then confirm -> ignored, state PAY, no pulses.
REQ-042 Bench SHALL cover cancel: coins 10+1+1 then cancel -> moneyReturn=12; change pulses 10, 1, 1; no ticket pulse.
REQ-043 Bench SHALL cover overflow and busy rejects: money=250, coin 10 -> coin_reject and money stays 250; a coin during DISPENSE -> coin_reject.
REQ-044 Bench SHALL cover simultaneous events: confirm and cancel in the same cycle -> cancel path; coin_valid and confirm in the same cycle -> coin added and confirm ignored.
REQ-045 Bench SHALL cover reset mid-operation: rst low during the 2nd of 5 ticket pulses -> all outputs 0 asynchronously; no pulses after release; state IDLE.

Source files
------------

// File: rtl/ticket_pkg.sv
// Shared types, coin codes, unit prices and price helpers for the ticket
// vending controller.
package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAY,
    ST_DISPENSE,
    ST_CHANGE,
    ST_DONE
  } state_t;

  // Inserted-coin codes on coin_value.
  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;

  // Ejected change-coin codes on change_coin.
  localparam logic [1:0] CHG_1  = 2'd0;
  localparam logic [1:0] CHG_5  = 2'd1;
  localparam logic [1:0] CHG_10 = 2'd2;

  // Unit prices per ticket type.
  localparam logic [7:0] PRICE_5  = 8'd5;
  localparam logic [7:0] PRICE_10 = 8'd10;
  localparam logic [7:0] PRICE_20 = 8'd20;
  localparam logic [7:0] PRICE_30 = 8'd30;

  function automatic logic [7:0] unit_price(input logic [2:0] ticket_type);
    case (ticket_type)
      3'd0:    return PRICE_5;
      3'd1:    return PRICE_10;
      3'd2:    return PRICE_20;
      default: return PRICE_30;
    endcase
  endfunction

  // Largest case is 30 x 7 = 210, so 8 bits never overflow.
  function automatic logic [7:0] price(input logic [2:0] ticket_type,
                                       input logic [2:0] ticket_count);
    logic [7:0] unit;
    unit = unit_price(ticket_type);
    return unit * {5'd0, ticket_count};
  endfunction

  function automatic logic [7:0] coin_amount(input logic [1:0] code);
    case (code)
      COIN_1:  return 8'd1;
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      default: return 8'd20;
    endcase
  endfunction

endpackage

// File: rtl/change_gen.sv
// Change decomposition: loads an amount on start, then ejects one coin per
// cycle (largest of 10/5/1 not exceeding the remainder) until nothing is left.
module change_gen
  import ticket_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  output logic       done,
  output logic       pulse,
  output logic [1:0] coin
);

  logic [7:0] remainder;
  logic       active;
  logic [1:0] pick_code;
  logic [7:0] pick_value;

  // Select the largest coin that still fits in the remainder.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    pick_code  = CHG_1;
    pick_value = 8'd1;
    if (remainder >= 8'd10) begin
      pick_code  = CHG_10;
      pick_value = 8'd10;
    end else if (remainder >= 8'd5) begin
      pick_code  = CHG_5;
      pick_value = 8'd5;
    end
  end

  // Finished once the loaded amount has been fully paid out (immediately for zero).
  assign done = active && (remainder == 8'd0);

  // Remainder register and registered coin pulse generation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remainder <= 8'd0;
      active    <= 1'b0;
      pulse     <= 1'b0;
      coin      <= 2'd0;
    end else begin
      pulse <= 1'b0;
      if (start) begin
        remainder <= amount;
        active    <= 1'b1;
      end else if (active) begin
        if (remainder == 8'd0) begin
          active <= 1'b0;
        end else begin
          pulse     <= 1'b1;
          coin      <= pick_code;
          remainder <= remainder - pick_value;
        end
      end
    end
  end

endmodule

// File: rtl/ticket_ctrl.sv
// Ticket vending controller: collects coins, dispenses tickets on a valid
// confirm, pays change through change_gen and holds the display in DONE.
module ticket_ctrl
  import ticket_pkg::*;
#(
  parameter int HOLD_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel_type,
  input  logic [2:0] sel_count,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       confirm,
  input  logic       cancel,
  output logic [7:0] money,
  output logic [2:0] ticketType,
  output logic [2:0] ticketCount,
  output logic [7:0] moneyReturn,
  output logic       ticket_pulse,
  output logic       change_pulse,
  output logic [1:0] change_coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t      state;
  logic [2:0]  tickets_left;
  logic [HW-1:0] hold_cnt;

  logic [7:0]  price_now;
  logic [8:0]  coin_sum;
  logic        coin_accept;
  logic [7:0]  money_next;
  logic        cancel_go;
  logic        confirm_go;
  logic        dispense_end;
  logic        change_start;
  logic [7:0]  change_amount;
  logic        change_done;

  assign price_now   = price(ticketType, ticketCount);
  // Ninth bit of the sum flags a coin that would push credit past 255.
  assign coin_sum    = {1'b0, money} + {1'b0, coin_amount(coin_value)};
  assign coin_accept = coin_valid &&
                       ((state == ST_IDLE) || ((state == ST_PAY) && !coin_sum[8]));
  assign money_next  = coin_accept ? coin_sum[7:0] : money;

  // Cancel beats a same-cycle confirm; a coin in the same cycle as confirm wins.
  assign cancel_go    = (state == ST_PAY) && cancel;
  assign confirm_go   = (state == ST_PAY) && confirm && !cancel && !coin_valid &&
                        (ticketCount != 3'd0) && (money >= price_now);
  assign dispense_end = (state == ST_DISPENSE) && (tickets_left == 3'd0);

  assign change_start  = cancel_go || dispense_end;
  assign change_amount = cancel_go ? money_next : (money - price_now);

  change_gen u_change_gen (
    .clk    (clk),
    .rst    (rst),
    .start  (change_start),
    .amount (change_amount),
    .done   (change_done),
    .pulse  (change_pulse),
    .coin   (change_coin)
  );

  // Transaction FSM with registered display, ticket, reject and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      money        <= 8'd0;
      moneyReturn  <= 8'd0;
      ticketType   <= 3'd0;
      ticketCount  <= 3'd0;
      ticket_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      tickets_left <= 3'd0;
      hold_cnt     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ticket_pulse <= 1'b0;
      coin_reject  <= coin_valid && !coin_accept;
      case (state)
        ST_IDLE: begin
          ticketType  <= sel_type;
          ticketCount <= sel_count;
          money       <= money_next;
          if (coin_accept) state <= ST_PAY;
        end
        ST_PAY: begin
          money <= money_next;
          if (cancel_go) begin
            moneyReturn <= change_amount;
            busy        <= 1'b1;
            state       <= ST_CHANGE;
          end else if (confirm_go) begin
            tickets_left <= ticketCount;
            busy         <= 1'b1;
            state        <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (tickets_left != 3'd0) begin
            ticket_pulse <= 1'b1;
            tickets_left <= tickets_left - 3'd1;
          end else begin
            moneyReturn <= change_amount;
            state       <= ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          if (change_done) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (hold_cnt == '0) begin
            money       <= 8'd0;
            moneyReturn <= 8'd0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_ctrl.sv
// Directed bench for ticket_ctrl: expected ticket pulses, change coins and
// coin rejects are queued as stimulus is applied and consumed by a monitor.
module tb_ticket_ctrl;
  import ticket_pkg::*;

  localparam int TB_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel_type;
  logic [2:0] sel_count;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       confirm;
  logic       cancel;
  logic [7:0] money;
  logic [2:0] ticketType;
  logic [2:0] ticketCount;
  logic [7:0] moneyReturn;
  logic       ticket_pulse;
  logic       change_pulse;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int tick_q[$];
  int chg_q[$];
  int rej_q[$];

  ticket_ctrl #(.HOLD_CYCLES(TB_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_type     (sel_type),
    .sel_count    (sel_count),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .confirm      (confirm),
    .cancel       (cancel),
    .money        (money),
    .ticketType   (ticketType),
    .ticketCount  (ticketCount),
    .moneyReturn  (moneyReturn),
    .ticket_pulse (ticket_pulse),
    .change_pulse (change_pulse),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: every pulse seen must match the head of its expectation queue.
  always @(negedge clk) begin
    int e;
    if (ticket_pulse || change_pulse)
      check("pulse_exclusive", 32'(ticket_pulse && change_pulse), 0);
    if (ticket_pulse) begin
      e = (tick_q.size() > 0) ? tick_q.pop_front() : 0;
      check("ticket_pulse_expected", 32'(ticket_pulse), e);
    end
    if (change_pulse) begin
      e = (chg_q.size() > 0) ? chg_q.pop_front() : -1;
      check("change_coin", 32'(change_coin), e);
    end
    if (coin_reject) begin
      e = (rej_q.size() > 0) ? rej_q.pop_front() : 0;
      check("coin_reject_expected", 32'(coin_reject), e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_value = code;
    cycle();
    coin_valid = 1'b0;
  endtask

  task automatic do_confirm();
    confirm = 1'b1;
    cycle();
    confirm = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
  endtask

  // Greedy change model: coins of 10, 5, 1 in that order.
  task automatic expect_change(input int amount);
    int a;
    a = amount;
    while (a > 0) begin
      if (a >= 10)     begin chg_q.push_back(CHG_10); a -= 10; end
      else if (a >= 5) begin chg_q.push_back(CHG_5);  a -= 5;  end
      else             begin chg_q.push_back(CHG_1);  a -= 1;  end
    end
  endtask

  task automatic expect_tickets(input int n);
    for (int i = 0; i < n; i++) tick_q.push_back(1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) cycle();
    check(tag, 32'(busy), 0);
    cycle();
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_tickets_left"}, tick_q.size(), 0);
    check({tag, "_change_left"},  chg_q.size(), 0);
    check({tag, "_reject_left"},  rej_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {money, moneyReturn, ticketType, ticketCount, ticket_pulse,
                change_pulse, change_coin, coin_reject, busy}, 0);
  endtask

  initial begin
    rst        = 1'b0;
    sel_type   = 3'd0;
    sel_count  = 3'd0;
    coin_valid = 1'b0;
    coin_value = 2'd0;
    confirm    = 1'b0;
    cancel     = 1'b0;

    // Reset state.
    repeat (2) cycle();
    check_all_zero("reset_outputs");
    rst = 1'b1;

    // IDLE tracks the selection.
    sel_type  = 3'd1;
    sel_count = 3'd2;
    cycle();
    check("idle_track_type", 32'(ticketType), 1);
    check("idle_track_count", 32'(ticketCount), 2);
    check("idle_money", 32'(money), 0);

    // Normal purchase: type 1 x2 = 20, pay 25, change 5.
    put_coin(COIN_20);
    check("buy_money_20", 32'(money), 20);
    sel_type = 3'd2;
    put_coin(COIN_5);
    check("buy_money_25", 32'(money), 25);
    check("buy_type_frozen", 32'(ticketType), 1);
    expect_tickets(2);
    expect_change(5);
    do_confirm();
    check("buy_busy", 32'(busy), 1);
    check("buy_no_pulse_at_entry", 32'(ticket_pulse), 0);
    cycle();
    check("buy_pulse1", 32'(ticket_pulse), 1);
    cycle();
    check("buy_pulse2", 32'(ticket_pulse), 1);
    cycle();
    check("buy_pulse_end", 32'(ticket_pulse), 0);
    check("buy_money_return", 32'(moneyReturn), 5);
    cycle();
    check("buy_change_pulse", 32'(change_pulse), 1);
    cycle();
    check("buy_done_busy", 32'(busy), 1);
    check("buy_done_return", 32'(moneyReturn), 5);
    check("buy_done_money", 32'(money), 25);
    repeat (TB_HOLD - 1) cycle();
    check("buy_hold_busy", 32'(busy), 1);
    cycle();
    check("buy_idle_busy", 32'(busy), 0);
    check("buy_idle_money", 32'(money), 0);
    check("buy_idle_return", 32'(moneyReturn), 0);
    check_queues("buy");

    // Insufficient credit: type 3 x3 = 90, pay 80.
    sel_type  = 3'd3;
    sel_count = 3'd3;
    cycle();
    repeat (4) put_coin(COIN_20);
    check("short_money", 32'(money), 80);
    do_confirm();
    cycle();
    check("short_busy", 32'(busy), 0);
    check("short_money_kept", 32'(money), 80);
    sel_count = 3'd1;
    put_coin(COIN_10);
    check("short_still_pay", 32'(money), 90);
    check("short_count_frozen", 32'(ticketCount), 3);
    expect_tickets(3);
    do_confirm();
    check("exact_busy", 32'(busy), 1);
    wait_idle("exact_idle");
    check_queues("exact");

    // Cancel: 10+1+1 returned as 10, 1, 1.
    sel_type  = 3'd0;
    sel_count = 3'd1;
    put_coin(COIN_10);
    put_coin(COIN_1);
    put_coin(COIN_1);
    check("cancel_money", 32'(money), 12);
    expect_change(12);
    do_cancel();
    check("cancel_return", 32'(moneyReturn), 12);
    check("cancel_busy", 32'(busy), 1);
    wait_idle("cancel_idle");
    check_queues("cancel");

    // Confirm and cancel together: cancel path.
    put_coin(COIN_5);
    expect_change(5);
    confirm = 1'b1;
    cancel  = 1'b1;
    cycle();
    confirm = 1'b0;
    cancel  = 1'b0;
    check("both_return", 32'(moneyReturn), 5);
    wait_idle("both_idle");
    check_queues("both");

    // Coin and confirm together: coin added, confirm ignored.
    put_coin(COIN_5);
    coin_valid = 1'b1;
    coin_value = COIN_1;
    confirm    = 1'b1;
    cycle();
    coin_valid = 1'b0;
    confirm    = 1'b0;
    check("coinconf_money", 32'(money), 6);
    check("coinconf_busy", 32'(busy), 0);
    expect_change(6);
    do_cancel();
    check("coinconf_return", 32'(moneyReturn), 6);
    wait_idle("coinconf_idle");
    check_queues("coinconf");

    // Overflow and busy rejects: type 3 x7 = 210.
    sel_type  = 3'd3;
    sel_count = 3'd7;
    repeat (12) put_coin(COIN_20);
    put_coin(COIN_10);
    check("ovf_money_250", 32'(money), 250);
    rej_q.push_back(1);
    put_coin(COIN_10);
    check("ovf_reject", 32'(coin_reject), 1);
    check("ovf_money_kept", 32'(money), 250);
    put_coin(COIN_5);
    check("ovf_money_255", 32'(money), 255);
    rej_q.push_back(1);
    put_coin(COIN_1);
    check("ovf_money_max", 32'(money), 255);
    expect_tickets(7);
    expect_change(45);
    do_confirm();
    cycle();
    rej_q.push_back(1);
    put_coin(COIN_1);
    check("busy_reject", 32'(coin_reject), 1);
    check("busy_money_kept", 32'(money), 255);
    wait_idle("ovf_idle");
    check_queues("ovf");

    // Reset during the second of five ticket pulses.
    sel_type  = 3'd0;
    sel_count = 3'd5;
    put_coin(COIN_20);
    put_coin(COIN_20);
    expect_tickets(1);
    do_confirm();
    cycle();
    cycle();
    check("rst_second_pulse", 32'(ticket_pulse), 1);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_async_outputs");
    cycle();
    cycle();
    rst       = 1'b1;
    sel_type  = 3'd2;
    sel_count = 3'd3;
    repeat (10) cycle();
    check("rst_idle_busy", 32'(busy), 0);
    check("rst_idle_type", 32'(ticketType), 2);
    check("rst_idle_count", 32'(ticketCount), 3);
    check("rst_idle_money", 32'(money), 0);
    check_queues("rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
